// File: rtl/bayer_mosaic_stream.sv
// bayer_mosaic_stream
// Turns a stream of RGB pixels into a single-channel Bayer raw stream.
// The block tracks the pixel position and keeps the one channel a sensor
// would sample at that site. Each output pixel carries its site type and
// start-of-frame and end-of-line flags. Valid/ready handshakes are used on
// both sides, and the output stage is a single register.

module bayer_mosaic_stream #(
  parameter int         WIDTH   = 640,
  parameter int         HEIGHT  = 480,
  parameter logic [1:0] PATTERN = 2'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_rgb,
  input  logic        in_sof,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_raw,
  output logic [1:0]  out_type,
  output logic        out_sof,
  output logic        out_eol,
  output logic        frame_misalign
);

  localparam logic [15:0] X_LAST = 16'(WIDTH - 1);
  localparam logic [15:0] Y_LAST = 16'(HEIGHT - 1);

  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] pos_x;
  logic [15:0] pos_y;
  logic [1:0]  site;
  logic [7:0]  chan;
  logic        accept;
  logic        at_origin;

  // The output register can take a new pixel when it is empty or is being drained.
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign at_origin = (x == 16'd0) && (y == 16'd0);

  // An in_sof pixel is placed at the origin. The site type and the channel follow from its position.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so a branch that is
    //       left out cannot infer a latch.
    pos_x = x;
    pos_y = y;
    chan  = in_rgb[15:8];
    if (in_sof) begin
      pos_x = 16'd0;
      pos_y = 16'd0;
    end
    site = PATTERN ^ {pos_y[0], pos_x[0]};
    case (site)
      2'd3:    chan = in_rgb[23:16];
      2'd0:    chan = in_rgb[7:0];
      default: chan = in_rgb[15:8];
    endcase
  end

  // Output register, position counters and the misalign pulse.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments. That way every
    //       right-hand side reads the value from before this edge.
    if (reset) begin
      out_valid      <= 1'b0;
      out_raw        <= 8'd0;
      out_type       <= 2'd0;
      out_sof        <= 1'b0;
      out_eol        <= 1'b0;
      frame_misalign <= 1'b0;
      x              <= 16'd0;
      y              <= 16'd0;
    end else begin
      frame_misalign <= accept && in_sof && !at_origin;
      if (accept) begin
        out_valid <= 1'b1;
        out_raw   <= chan;
        out_type  <= site;
        out_sof   <= (pos_x == 16'd0) && (pos_y == 16'd0);
        out_eol   <= (pos_x == X_LAST);
        if (pos_x == X_LAST) begin
          x <= 16'd0;
          y <= (pos_y == Y_LAST) ? 16'd0 : pos_y + 16'd1;
        end else begin
          x <= pos_x + 16'd1;
          y <= pos_y;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bayer_mosaic_stream.sv
// Testbench for bayer_mosaic_stream.
// Three instances share one stimulus stream: BGGR 4x2, RGGB 4x2 and GRBG 5x3.
// A frame-index reference model predicts every output of every instance.

module tb_bayer_mosaic_stream;

  localparam int         ND      = 3;
  localparam int         PW [ND] = '{4, 4, 5};
  localparam int         PH [ND] = '{2, 2, 3};
  localparam logic [1:0] PP [ND] = '{2'd0, 2'd3, 2'd2};

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [23:0] in_rgb;
  logic        in_sof;
  logic        out_ready;

  logic [ND-1:0] ov, ir, osof, oeol, omis;
  logic [7:0]    oraw  [ND];
  logic [1:0]    otype [ND];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: the output register contents and the frame index.
  bit         m_valid [ND];
  logic [7:0] m_raw   [ND];
  logic [1:0] m_type  [ND];
  bit         m_sof   [ND];
  bit         m_eol   [ND];
  bit         m_mis   [ND];
  int         m_idx   [ND];
  int         mis_count [ND];
  bit         last_acc;

  // Transfers seen on instances 0 and 1, packed as {sof, eol, type, raw}.
  logic [11:0] q0[$];
  logic [11:0] q1[$];

  always #5 clk = ~clk;

  bayer_mosaic_stream #(.WIDTH(4), .HEIGHT(2), .PATTERN(2'd0)) u_bggr (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]),
    .in_rgb(in_rgb), .in_sof(in_sof), .out_valid(ov[0]), .out_ready(out_ready),
    .out_raw(oraw[0]), .out_type(otype[0]), .out_sof(osof[0]), .out_eol(oeol[0]),
    .frame_misalign(omis[0]));

  bayer_mosaic_stream #(.WIDTH(4), .HEIGHT(2), .PATTERN(2'd3)) u_rggb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]),
    .in_rgb(in_rgb), .in_sof(in_sof), .out_valid(ov[1]), .out_ready(out_ready),
    .out_raw(oraw[1]), .out_type(otype[1]), .out_sof(osof[1]), .out_eol(oeol[1]),
    .frame_misalign(omis[1]));

  bayer_mosaic_stream #(.WIDTH(5), .HEIGHT(3), .PATTERN(2'd2)) u_grbg (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]),
    .in_rgb(in_rgb), .in_sof(in_sof), .out_valid(ov[2]), .out_ready(out_ready),
    .out_raw(oraw[2]), .out_type(otype[2]), .out_sof(osof[2]), .out_eol(oeol[2]),
    .frame_misalign(omis[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_valid[d] = 0; m_raw[d] = '0; m_type[d] = '0;
      m_sof[d] = 0; m_eol[d] = 0; m_mis[d] = 0; m_idx[d] = 0;
    end
  endtask

  // Runs one clock. At the falling edge it compares the outputs with the model
  // and then advances the model using the inputs driven this cycle.
  task automatic cycle();
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      bit   exp_ir, acc;
      int   pos, px, py;
      logic [1:0] t;
      logic [23:0] c;
      exp_ir = !m_valid[d] || out_ready;
      check($sformatf("d%0d out_valid", d), 32'(ov[d]), 32'(m_valid[d]));
      check($sformatf("d%0d in_ready", d), 32'(ir[d]), 32'(exp_ir));
      check($sformatf("d%0d misalign", d), 32'(omis[d]), 32'(m_mis[d]));
      if (m_valid[d]) begin
        check($sformatf("d%0d raw", d), 32'(oraw[d]), 32'(m_raw[d]));
        check($sformatf("d%0d type", d), 32'(otype[d]), 32'(m_type[d]));
        check($sformatf("d%0d sof", d), 32'(osof[d]), 32'(m_sof[d]));
        check($sformatf("d%0d eol", d), 32'(oeol[d]), 32'(m_eol[d]));
      end
      if (omis[d]) mis_count[d]++;
      if (ov[d] && out_ready) begin
        if (d == 0) q0.push_back({osof[d], oeol[d], otype[d], oraw[d]});
        if (d == 1) q1.push_back({osof[d], oeol[d], otype[d], oraw[d]});
      end
      acc = in_valid && exp_ir;
      if (d == 0) last_acc = acc && !reset;
      if (reset) begin
        m_valid[d] = 0; m_raw[d] = '0; m_type[d] = '0;
        m_sof[d] = 0; m_eol[d] = 0; m_mis[d] = 0; m_idx[d] = 0;
      end else begin
        m_mis[d] = acc && in_sof && (m_idx[d] != 0);
        if (acc) begin
          pos = in_sof ? 0 : m_idx[d];
          px  = pos % PW[d];
          py  = pos / PW[d];
          t   = PP[d] ^ 2'((py % 2) * 2 + (px % 2));
          c   = in_rgb;
          m_type[d]  = t;
          m_raw[d]   = (t == 2'd3) ? c[23:16] : (t == 2'd0) ? c[7:0] : c[15:8];
          m_sof[d]   = (pos == 0);
          m_eol[d]   = (px == PW[d] - 1);
          m_idx[d]   = (pos + 1) % (PW[d] * PH[d]);
          m_valid[d] = 1;
        end else if (out_ready) begin
          m_valid[d] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    q0.delete(); q1.delete();
    for (int d = 0; d < ND; d++) mis_count[d] = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] bggr_t [8];
    logic [7:0] bggr_r [8];
    logic [1:0] rggb_t [8];
    logic [7:0] rggb_r [8];
    int p;
    bggr_t = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3};
    bggr_r = '{8'h33, 8'h22, 8'h33, 8'h22, 8'h22, 8'h11, 8'h22, 8'h11};
    rggb_t = '{2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd0};
    rggb_r = '{8'h11, 8'h22, 8'h11, 8'h22, 8'h22, 8'h33, 8'h22, 8'h33};

    reset = 1'b1; in_valid = 1'b0; in_rgb = '0; in_sof = 1'b0; out_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Values straight after reset.
    check("rst out_valid", 32'(ov[0]), 32'd0);
    check("rst out_raw", 32'(oraw[0]), 32'd0);
    check("rst out_type", 32'(otype[1]), 32'd0);
    check("rst flags", 32'({osof[0], oeol[0], omis[0]}), 32'd0);

    // Constant 112233 stream, 16 pixels with in_sof only on the first, out_ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_rgb = 24'h112233; in_sof = (i == 0);
      cycle();
    end
    in_valid = 1'b0; in_sof = 1'b0;
    cycle(); cycle();
    check("stream count", 32'(q0.size()), 32'd16);
    if (q0.size() == 16 && q1.size() == 16) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("bggr type[%0d]", i), 32'(q0[i][9:8]), 32'(bggr_t[i]));
        check($sformatf("bggr raw[%0d]", i), 32'(q0[i][7:0]), 32'(bggr_r[i]));
        check($sformatf("bggr sof[%0d]", i), 32'(q0[i][11]), 32'(i == 0));
        check($sformatf("bggr eol[%0d]", i), 32'(q0[i][10]), 32'(i == 3 || i == 7));
        check($sformatf("rggb type[%0d]", i), 32'(q1[i][9:8]), 32'(rggb_t[i]));
        check($sformatf("rggb raw[%0d]", i), 32'(q1[i][7:0]), 32'(rggb_r[i]));
      end
      check("wrap sof px8", 32'(q0[8][11]), 32'd1);
      check("wrap type px8", 32'(q0[8][9:8]), 32'd0);
    end
    check("wrap no misalign", 32'(mis_count[0]), 32'd0);

    // Backpressure: out_ready drops for 3 cycles after the first accept. The source holds its pixel while stalled.
    do_reset();
    p = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_sof = 1'b1; in_rgb = 24'h0A0B0C;
    cycle();
    p = 1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_sof = 1'b0; in_rgb = {8'(p), 8'(p + 8'h40), 8'(p + 8'h80)};
      cycle();
      check("bp held raw", 32'(oraw[0]), 32'h0C);
    end
    out_ready = 1'b1;
    while (p < 8) begin
      in_valid = 1'b1; in_sof = 1'b0; in_rgb = {8'(p), 8'(p + 8'h40), 8'(p + 8'h80)};
      cycle();
      if (last_acc) p++;
    end
    in_valid = 1'b0;
    cycle(); cycle();
    check("bp count", 32'(q0.size()), 32'd8);

    // Misalign: in_sof on pixel 5, which is position (1,1) of the 4x2 frame.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_rgb = 24'h112233; in_sof = (i == 0 || i == 5);
      cycle();
    end
    in_valid = 1'b0; in_sof = 1'b0;
    cycle(); cycle();
    check("mis pulses", 32'(mis_count[0]), 32'd1);
    if (q0.size() == 8) begin
      check("mis px5 type", 32'(q0[5][9:8]), 32'd0);
      check("mis px5 sof", 32'(q0[5][11]), 32'd1);
      check("mis px6 type", 32'(q0[6][9:8]), 32'd1);
    end else begin
      check("mis count", 32'(q0.size()), 32'd8);
    end

    // Reset one cycle while the output register is full and stalled.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_rgb = 24'h445566; in_sof = (i == 0);
      cycle();
    end
    out_ready = 1'b0; in_valid = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    q0.delete(); q1.delete();
    check("mid rst valid", 32'(ov[0]), 32'd0);
    check("mid rst ready", 32'(ir[0]), 32'd1);
    out_ready = 1'b1; in_valid = 1'b1; in_sof = 1'b0; in_rgb = 24'h778899;
    cycle();
    in_valid = 1'b0;
    cycle();
    if (q0.size() == 1 && q1.size() == 1) begin
      check("post rst type bggr", 32'(q0[0][9:8]), 32'd0);
      check("post rst type rggb", 32'(q1[0][9:8]), 32'd3);
      check("post rst sof", 32'(q0[0][11]), 32'd1);
    end else begin
      check("post rst count", 32'(q0.size()), 32'd1);
    end

    // Random traffic with occasional in_sof and reset. The source holds a pixel until it is accepted.
    do_reset();
    in_valid = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_rgb   = 24'($urandom);
        in_sof   = ($urandom_range(0, 29) == 0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      reset     = ($urandom_range(0, 499) == 0);
      cycle();
      reset = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
